// File: rtl/sr_mc_control.sv
// sr_mc_control -- multi-cycle control unit for the schoolRISCV core.
//
// Decodes {cmdF7, cmdF3, cmdOp} and sequences instructions that need more than
// one cycle: MUL (fixed latency) and LW/SW (memory ready handshake with an
// optional abort timeout). The PC is stalled through pcEn while such an
// instruction is in flight; the datapath keeps the instruction word stable
// meanwhile, so the decode is simply re-evaluated every cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmdOp/F3/F7       instruction fields
//   aluZero           ALU result is zero (branch condition)
//   memReady          data memory completes the current access this cycle
//   pcSrc             take the branch target
//   pcEn              PC update enable / instruction retire strobe
//   regWrite          register file write enable (retire cycle only)
//   aluSrc            0: rs2, 1: immediate
//   wdSrc             00: ALU, 01: U-immediate, 10: memory read data
//   aluControl        ALU operation
//   memReq, memWe     data memory request and store qualifier
//   busy              an instruction is in flight beyond its decode cycle
//   illegal           one-cycle pulse on an unknown encoding
//   memTimeout        sticky flag: a memory access was aborted
module sr_mc_control #(
   parameter int ALU_CTRL_W  = 4,
   parameter int MUL_LATENCY = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            cmdOp,
   input  logic [2:0]            cmdF3,
   input  logic [6:0]            cmdF7,
   input  logic                  aluZero,
   input  logic                  memReady,
   output logic                  pcSrc,
   output logic                  pcEn,
   output logic                  regWrite,
   output logic                  aluSrc,
   output logic [1:0]            wdSrc,
   output logic [ALU_CTRL_W-1:0] aluControl,
   output logic                  memReq,
   output logic                  memWe,
   output logic                  busy,
   output logic                  illegal,
   output logic                  memTimeout
);

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(4'd0);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(4'd1);
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(4'd2);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(4'd3);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(4'd4);
   localparam logic [ALU_CTRL_W-1:0] ALU_KSLL8 = ALU_CTRL_W'(4'd5);
   localparam logic [ALU_CTRL_W-1:0] ALU_MUL   = ALU_CTRL_W'(4'd6);

   localparam bit         MUL_MULTI = (MUL_LATENCY > 1);
   localparam logic [3:0] MUL_LOAD  = 4'(MUL_LATENCY - 1);
   localparam bit         TMO_EN    = (MEM_TIMEOUT != 0);
   localparam int         WCNT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_DECODE = 2'd0,
      S_MUL    = 2'd1,
      S_MEM    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                mem_timeout_q, mem_timeout_d;

   logic                  dec_reg_write_s, dec_alu_src_s, dec_branch_s, dec_cond_zero_s;
   logic                  dec_mul_s, dec_load_s, dec_store_s, dec_illegal_s;
   logic [1:0]            dec_wd_src_s;
   logic [ALU_CTRL_W-1:0] dec_alu_ctrl_s;

   logic                  pc_src_s, pc_en_s, reg_write_s, alu_src_s;
   logic                  mem_req_s, mem_we_s, illegal_s;
   logic [1:0]            wd_src_s;
   logic [ALU_CTRL_W-1:0] alu_ctrl_s;

   // Instruction decode; KSLL8 occupies the free R-type slot F7=0, F3=001.
   always_comb begin
      dec_reg_write_s = 1'b0;
      dec_alu_src_s   = 1'b0;
      dec_branch_s    = 1'b0;
      dec_cond_zero_s = 1'b0;
      dec_mul_s       = 1'b0;
      dec_load_s      = 1'b0;
      dec_store_s     = 1'b0;
      dec_illegal_s   = 1'b0;
      dec_wd_src_s    = 2'b00;
      dec_alu_ctrl_s  = ALU_ADD;
      casez ({cmdF7, cmdF3, cmdOp})
         17'b0000000_000_0110011: begin dec_reg_write_s = 1'b1; dec_alu_ctrl_s = ALU_ADD;   end
         17'b0000000_110_0110011: begin dec_reg_write_s = 1'b1; dec_alu_ctrl_s = ALU_OR;    end
         17'b0000000_101_0110011: begin dec_reg_write_s = 1'b1; dec_alu_ctrl_s = ALU_SRL;   end
         17'b0000000_011_0110011: begin dec_reg_write_s = 1'b1; dec_alu_ctrl_s = ALU_SLTU;  end
         17'b0100000_000_0110011: begin dec_reg_write_s = 1'b1; dec_alu_ctrl_s = ALU_SUB;   end
         17'b0000000_001_0110011: begin dec_reg_write_s = 1'b1; dec_alu_ctrl_s = ALU_KSLL8; end
         17'b0000001_000_0110011: begin
            dec_reg_write_s = 1'b1;
            dec_mul_s       = 1'b1;
            dec_alu_ctrl_s  = ALU_MUL;
         end
         17'b???????_000_0010011: begin dec_reg_write_s = 1'b1; dec_alu_src_s = 1'b1; end
         17'b???????_???_0110111: begin dec_reg_write_s = 1'b1; dec_wd_src_s = 2'b01; end
         17'b???????_000_1100011: begin dec_branch_s = 1'b1; dec_cond_zero_s = 1'b1; dec_alu_ctrl_s = ALU_SUB;  end
         17'b???????_001_1100011: begin dec_branch_s = 1'b1; dec_cond_zero_s = 1'b0; dec_alu_ctrl_s = ALU_SUB;  end
         17'b???????_110_1100011: begin dec_branch_s = 1'b1; dec_cond_zero_s = 1'b0; dec_alu_ctrl_s = ALU_SLTU; end
         17'b???????_111_1100011: begin dec_branch_s = 1'b1; dec_cond_zero_s = 1'b1; dec_alu_ctrl_s = ALU_SLTU; end
         17'b???????_010_0000011: begin
            dec_load_s    = 1'b1;
            dec_alu_src_s = 1'b1;
            dec_wd_src_s  = 2'b10;
         end
         17'b???????_010_0100011: begin dec_store_s = 1'b1; dec_alu_src_s = 1'b1; end
         default:                 dec_illegal_s = 1'b1;
      endcase
   end

   // Control outputs and next-state logic for the instruction sequencer.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wcnt_d        = wcnt_q;
      mem_timeout_d = mem_timeout_q;
      pc_src_s      = 1'b0;
      pc_en_s       = 1'b0;
      reg_write_s   = 1'b0;
      alu_src_s     = 1'b0;
      wd_src_s      = 2'b00;
      alu_ctrl_s    = ALU_ADD;
      mem_req_s     = 1'b0;
      mem_we_s      = 1'b0;
      illegal_s     = 1'b0;
      case (state_q)
         S_DECODE: begin
            alu_src_s  = dec_alu_src_s;
            wd_src_s   = dec_wd_src_s;
            alu_ctrl_s = dec_alu_ctrl_s;
            illegal_s  = dec_illegal_s;
            pc_src_s   = dec_branch_s & (aluZero == dec_cond_zero_s);
            if (dec_mul_s && MUL_MULTI) begin
               cnt_d   = MUL_LOAD;
               state_d = S_MUL;
            end else if (dec_load_s || dec_store_s) begin
               mem_req_s = 1'b1;
               mem_we_s  = dec_store_s;
               if (memReady) begin
                  pc_en_s     = 1'b1;
                  reg_write_s = dec_load_s;
               end else begin
                  // The decode cycle is wait cycle 0, so S_MEM starts at 1.
                  wcnt_d  = WCNT_W'(1'b1);
                  state_d = S_MEM;
               end
            end else begin
               pc_en_s     = 1'b1;
               reg_write_s = dec_reg_write_s;
            end
         end
         S_MUL: begin
            alu_ctrl_s = ALU_MUL;
            if (cnt_q == 4'd1) begin
               pc_en_s     = 1'b1;
               reg_write_s = 1'b1;
               cnt_d       = 4'd0;
               state_d     = S_DECODE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_MEM: begin
            mem_req_s  = 1'b1;
            mem_we_s   = dec_store_s;
            alu_src_s  = 1'b1;
            alu_ctrl_s = ALU_ADD;
            wd_src_s   = dec_wd_src_s;
            if (memReady) begin
               pc_en_s     = 1'b1;
               reg_write_s = dec_load_s;
               wcnt_d      = WCNT_W'(1'b0);
               state_d     = S_DECODE;
            end else if (TMO_EN && (wcnt_q >= WCNT_LAST)) begin
               // Abort: retire as a NOP and flag it permanently.
               pc_en_s       = 1'b1;
               mem_timeout_d = 1'b1;
               wcnt_d        = WCNT_W'(1'b0);
               state_d       = S_DECODE;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1'b1);
            end
         end
         default: begin
            state_d = S_DECODE;
         end
      endcase
   end

   // Sequencer state, latency counter, wait counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_DECODE;
         cnt_q         <= 4'd0;
         wcnt_q        <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wcnt_q        <= wcnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Side-effecting strobes are gated by rst_n so a reset drops them at once.
   assign pcSrc      = rst_n & pc_src_s;
   assign pcEn       = rst_n & pc_en_s;
   assign regWrite   = rst_n & reg_write_s;
   assign memReq     = rst_n & mem_req_s;
   assign memWe      = rst_n & mem_we_s;
   assign illegal    = rst_n & illegal_s;
   assign aluSrc     = alu_src_s;
   assign wdSrc      = wd_src_s;
   assign aluControl = alu_ctrl_s;
   assign busy       = (state_q != S_DECODE);
   assign memTimeout = mem_timeout_q;

endmodule

// File: tb/tb_sr_mc_control.sv
`timescale 1ns/1ps
module tb_sr_mc_control;
   localparam int MUL_LAT = 3;
   localparam int MEM_TMO = 15;

   localparam logic [3:0] A_ADD = 4'd0, A_OR = 4'd1, A_SRL = 4'd2, A_SLTU = 4'd3;
   localparam logic [3:0] A_SUB = 4'd4, A_KSLL8 = 4'd5, A_MUL = 4'd6;

   localparam int K_SIMPLE = 0, K_BR = 1, K_MUL = 2, K_LD = 3, K_ST = 4, K_ILL = 5;

   typedef struct {
      int         kind;
      logic       rw;
      logic       asrc;
      logic [1:0] wd;
      logic [3:0] ctrl;
      logic       cz;
   } dec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] cmdOp = 7'd0;
   logic [2:0] cmdF3 = 3'd0;
   logic [6:0] cmdF7 = 7'd0;
   logic       aluZero = 1'b0;
   logic       memReady = 1'b0;
   logic       pcSrc, pcEn, regWrite, aluSrc, memReq, memWe, busy, illegal, memTimeout;
   logic [1:0] wdSrc;
   logic [3:0] aluControl;

   int   compared = 0;
   int   mismatched = 0;
   logic tmo_model = 1'b0;

   logic [14:0] obs;
   assign obs = {pcSrc, pcEn, regWrite, aluSrc, wdSrc, aluControl, memReq, memWe, busy, illegal, memTimeout};

   sr_mc_control #(.ALU_CTRL_W(4), .MUL_LATENCY(MUL_LAT), .MEM_TIMEOUT(MEM_TMO)) dut (
      .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
      .aluZero(aluZero), .memReady(memReady), .pcSrc(pcSrc), .pcEn(pcEn),
      .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl),
      .memReq(memReq), .memWe(memWe), .busy(busy), .illegal(illegal), .memTimeout(memTimeout)
   );

   always #5 clk = ~clk;

   // Reference classification of an instruction word straight from the ISA table.
   function automatic dec_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      dec_t d;
      d.kind = K_ILL; d.rw = 1'b0; d.asrc = 1'b0; d.wd = 2'b00; d.ctrl = A_ADD; d.cz = 1'b0;
      if (op == 7'b0110011) begin
         if (f7 == 7'b0000000 && f3 == 3'b000) begin d.kind = K_SIMPLE; d.rw = 1'b1; d.ctrl = A_ADD; end
         else if (f7 == 7'b0000000 && f3 == 3'b110) begin d.kind = K_SIMPLE; d.rw = 1'b1; d.ctrl = A_OR; end
         else if (f7 == 7'b0000000 && f3 == 3'b101) begin d.kind = K_SIMPLE; d.rw = 1'b1; d.ctrl = A_SRL; end
         else if (f7 == 7'b0000000 && f3 == 3'b011) begin d.kind = K_SIMPLE; d.rw = 1'b1; d.ctrl = A_SLTU; end
         else if (f7 == 7'b0000000 && f3 == 3'b001) begin d.kind = K_SIMPLE; d.rw = 1'b1; d.ctrl = A_KSLL8; end
         else if (f7 == 7'b0100000 && f3 == 3'b000) begin d.kind = K_SIMPLE; d.rw = 1'b1; d.ctrl = A_SUB; end
         else if (f7 == 7'b0000001 && f3 == 3'b000) begin d.kind = K_MUL; end
      end else if (op == 7'b0010011 && f3 == 3'b000) begin
         d.kind = K_SIMPLE; d.rw = 1'b1; d.asrc = 1'b1;
      end else if (op == 7'b0110111) begin
         d.kind = K_SIMPLE; d.rw = 1'b1; d.wd = 2'b01;
      end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b110 || f3 == 3'b111)) begin
         d.kind = K_BR;
         d.ctrl = (f3 >= 3'b110) ? A_SLTU : A_SUB;
         d.cz   = (f3 == 3'b000) || (f3 == 3'b111);
      end else if (op == 7'b0000011 && f3 == 3'b010) begin
         d.kind = K_LD;
      end else if (op == 7'b0100011 && f3 == 3'b010) begin
         d.kind = K_ST;
      end
      return d;
   endfunction

   // One cycle: predict outputs from the instruction class and elapsed cycles, compare at negedge.
   task automatic check_cycle(input dec_t d, input int el, input logic rdy, input string tag,
                              output logic retired, output logic aborted);
      logic ps, pe, rw, as, mr, mw, il;
      logic [1:0] wd;
      logic [3:0] ct;
      logic [14:0] exp_v;
      ps = 1'b0; pe = 1'b0; rw = 1'b0; as = 1'b0; mr = 1'b0; mw = 1'b0; il = 1'b0;
      wd = 2'b00; ct = A_ADD; aborted = 1'b0;
      memReady = rdy;
      case (d.kind)
         K_SIMPLE: begin pe = 1'b1; rw = d.rw; as = d.asrc; wd = d.wd; ct = d.ctrl; end
         K_BR:     begin pe = 1'b1; ct = d.ctrl; ps = (aluZero == d.cz); end
         K_MUL:    begin ct = A_MUL; pe = (el == MUL_LAT - 1); rw = pe; end
         K_LD, K_ST: begin
            mr = 1'b1; mw = (d.kind == K_ST); as = 1'b1;
            wd = (d.kind == K_LD) ? 2'b10 : 2'b00;
            if (rdy) begin
               pe = 1'b1; rw = (d.kind == K_LD);
            end else if (MEM_TMO != 0 && el == MEM_TMO - 1) begin
               pe = 1'b1; aborted = 1'b1;
            end
         end
         default:  begin pe = 1'b1; il = 1'b1; end
      endcase
      exp_v = {ps, pe, rw, as, wd, ct, mr, mw, (el > 0), il, tmo_model};
      retired = pe;
      @(negedge clk);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, el, obs, exp_v);
      end
   endtask

   // Apply one instruction until the model says it retires; ready_at<0 means memReady never rises.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input int ready_at, input string tag);
      dec_t d;
      int   el;
      logic done, ret, ab;
      d = ref_decode(op, f3, f7);
      cmdOp = op; cmdF3 = f3; cmdF7 = f7; aluZero = z;
      el = 0; done = 1'b0;
      while (!done && el < 40) begin
         check_cycle(d, el, (ready_at >= 0) && (el >= ready_at), tag, ret, ab);
         @(posedge clk); #1;
         if (ab) tmo_model = 1'b1;
         done = ret;
         el++;
      end
   endtask

   // While rst_n is low every strobe, busy and the sticky flag must read 0.
   task automatic check_reset(input string tag);
      #1;
      compared++;
      assert ({pcSrc, pcEn, regWrite, memReq, memWe, illegal, busy, memTimeout} === 8'h00) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=00000000", tag,
                {pcSrc, pcEn, regWrite, memReq, memWe, illegal, busy, memTimeout});
      end
   endtask

   initial begin
      dec_t d;
      logic r, a;
      int   k;
      logic [6:0] op, f7;
      logic [2:0] f3;
      int   rdy_at;

      // Reset with an ADD and memReady present: strobes must still be 0.
      cmdOp = 7'b0110011; memReady = 1'b1;
      #2 check_reset("reset_init");
      @(posedge clk); #1 rst_n = 1'b1;

      run_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, "add");
      run_instr(7'b0010011, 3'b000, 7'b1010101, 1'b0, 0, "addi");
      run_instr(7'b0110111, 3'b101, 7'b0011001, 1'b0, 0, "lui");
      run_instr(7'b0110011, 3'b110, 7'b0000000, 1'b0, 0, "or");
      run_instr(7'b0110011, 3'b101, 7'b0000000, 1'b0, 0, "srl");
      run_instr(7'b0110011, 3'b011, 7'b0000000, 1'b0, 0, "sltu");
      run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, "sub");
      run_instr(7'b0110011, 3'b001, 7'b0000000, 1'b0, 0, "ksll8");
      run_instr(7'b0110011, 3'b000, 7'b0000001, 1'b0, 0, "mul_a");
      run_instr(7'b0110011, 3'b000, 7'b0000001, 1'b0, 0, "mul_b");
      run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 2, "lw_wait2");
      run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, "lw_fast");
      run_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, "sw_fast");
      run_instr(7'b1100011, 3'b111, 7'b0000000, 1'b1, 0, "bgeu_z1");
      run_instr(7'b1100011, 3'b110, 7'b0000000, 1'b1, 0, "bltu_z1");
      run_instr(7'b1100011, 3'b001, 7'b0000000, 1'b0, 0, "bne_z0");
      run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, "beq_z1");
      run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, "beq_z0");
      run_instr(7'b1111111, 3'b000, 7'b0000000, 1'b0, 0, "illegal_op");
      run_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0, -1, "sw_timeout");
      run_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, "add_sticky");
      run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1, "lw_sticky");

      // Reset while the MUL counter sits at its last step.
      cmdOp = 7'b0110011; cmdF3 = 3'b000; cmdF7 = 7'b0000001;
      d = ref_decode(cmdOp, cmdF3, cmdF7);
      check_cycle(d, 0, 1'b0, "rst_mul", r, a);
      @(posedge clk); #1;
      check_cycle(d, 1, 1'b0, "rst_mul", r, a);
      @(posedge clk); #1;
      rst_n = 1'b0;
      tmo_model = 1'b0;
      check_reset("rst_mul_low");
      @(posedge clk); #1 rst_n = 1'b1;
      run_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, "after_rst_mul");

      // Reset while a load waits for memory.
      cmdOp = 7'b0000011; cmdF3 = 3'b010; cmdF7 = 7'b0000000;
      d = ref_decode(cmdOp, cmdF3, cmdF7);
      check_cycle(d, 0, 1'b0, "rst_lw", r, a);
      @(posedge clk); #1;
      rst_n = 1'b0;
      check_reset("rst_lw_low");
      @(posedge clk); #1 rst_n = 1'b1;
      run_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, "after_rst_lw");

      // Randomized instruction stream.
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 9);
         f7 = 7'($urandom_range(0, 127));
         f3 = 3'($urandom_range(0, 7));
         case (k)
            0: begin op = 7'b0110011; f7 = 7'b0000000; end
            1: begin op = 7'b0110011; f7 = 7'b0000001; f3 = 3'b000; end
            2: begin op = 7'b0110011; f7 = ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'b0000000; end
            3: op = 7'b0010011;
            4: op = 7'b0110111;
            5: op = 7'b1100011;
            6: begin op = 7'b0000011; f3 = 3'b010; end
            7: begin op = 7'b0100011; f3 = 3'b010; end
            default: op = 7'($urandom_range(0, 127));
         endcase
         rdy_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
         run_instr(op, f3, f7, 1'($urandom_range(0, 1)), rdy_at, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
